// File: rtl/sym9_sweep_ctrl.sv
// Exhaustive self-test sequencer for an N_IN-input symmetric-function datapath:
// sweeps every input vector, checks the datapath output against a popcount model.
module sym9_sweep_ctrl #(
  parameter int N_IN   = 9,
  parameter int SYM_LO = 3,
  parameter int SYM_HI = 6,
  parameter int LAT    = 0,
  parameter int CNT_W  = 10
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   vec_o,
  output logic              vec_valid_o,
  input  logic              dut_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [N_IN-1:0]   first_err_vec,
  output logic              first_err_valid
);
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_FIN} state_t;

  function automatic int f_binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int f_exp_total();
    int s = 0;
    for (int k = SYM_LO; k <= SYM_HI; k++) s += f_binom(N_IN, k);
    return s;
  endfunction

  function automatic int f_popcnt(input logic [N_IN-1:0] v);
    int c = 0;
    for (int i = 0; i < N_IN; i++) c += int'(v[i]);
    return c;
  endfunction

  localparam logic [CNT_W-1:0] EXP_TOTAL = CNT_W'(f_exp_total());
  localparam logic [1:0]       DRN_LAST  = 2'((LAT > 0) ? LAT - 1 : 0);

  state_t           r_state;
  logic [1:0]       r_drn;
  int               w_pc;
  logic             w_exp;
  logic             w_cmp_vld, w_cmp_exp;
  logic [N_IN-1:0]  w_cmp_vec;
  logic             w_flush, w_mis, w_pass_nxt;
  logic [CNT_W-1:0] w_ones_nxt, w_err_nxt;

  assign w_pc    = f_popcnt(vec_o);
  assign w_exp   = (w_pc >= SYM_LO) && (w_pc <= SYM_HI);
  assign w_flush = abort && (r_state == S_DRIVE || r_state == S_DRAIN);

  // Align expected value and vector with the datapath output LAT cycles later.
  if (LAT == 0) begin : g_nodly
    assign w_cmp_vld = vec_valid_o;
    assign w_cmp_exp = w_exp;
    assign w_cmp_vec = vec_o;
  end else begin : g_dly
    logic [LAT-1:0]           r_vld_sh, r_exp_sh;
    logic [LAT-1:0][N_IN-1:0] r_vec_sh;
    always_ff @(posedge clk) begin
      if (rst || w_flush) begin
        r_vld_sh <= '0;
        r_exp_sh <= '0;
        r_vec_sh <= '0;
      end else begin
        r_vld_sh[0] <= vec_valid_o;
        r_exp_sh[0] <= w_exp;
        r_vec_sh[0] <= vec_o;
        for (int i = 1; i < LAT; i++) begin
          r_vld_sh[i] <= r_vld_sh[i-1];
          r_exp_sh[i] <= r_exp_sh[i-1];
          r_vec_sh[i] <= r_vec_sh[i-1];
        end
      end
    end
    assign w_cmp_vld = r_vld_sh[LAT-1];
    assign w_cmp_exp = r_exp_sh[LAT-1];
    assign w_cmp_vec = r_vec_sh[LAT-1];
  end

  assign w_mis      = w_cmp_vld && (dut_i != w_cmp_exp);
  assign w_ones_nxt = ones_cnt + CNT_W'(w_cmp_vld && dut_i);
  assign w_err_nxt  = err_cnt + CNT_W'(w_mis);
  // Pass is resolved with the last compare folded in, so it is valid alongside done.
  assign w_pass_nxt = (w_err_nxt == '0) && (w_ones_nxt == EXP_TOTAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_drn           <= '0;
      vec_o           <= '0;
      vec_valid_o     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      ones_cnt        <= '0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_cmp_vld) begin
        ones_cnt <= w_ones_nxt;
        err_cnt  <= w_err_nxt;
        if (w_mis && !first_err_valid) begin
          first_err_vec   <= w_cmp_vec;
          first_err_valid <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: if (start) begin
          ones_cnt        <= '0;
          err_cnt         <= '0;
          pass            <= 1'b0;
          first_err_vec   <= '0;
          first_err_valid <= 1'b0;
          vec_o           <= '0;
          vec_valid_o     <= 1'b1;
          busy            <= 1'b1;
          r_state         <= S_DRIVE;
        end
        S_DRIVE: if (abort) begin
          vec_o       <= '0;
          vec_valid_o <= 1'b0;
          busy        <= 1'b0;
          pass        <= 1'b0;
          r_state     <= S_IDLE;
        end else if (vec_o == {N_IN{1'b1}}) begin
          vec_o       <= '0;
          vec_valid_o <= 1'b0;
          r_drn       <= '0;
          if (LAT > 0) begin
            r_state <= S_DRAIN;
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= w_pass_nxt;
            r_state <= S_FIN;
          end
        end else begin
          vec_o <= vec_o + 1'b1;
        end
        S_DRAIN: if (abort) begin
          busy    <= 1'b0;
          pass    <= 1'b0;
          r_state <= S_IDLE;
        end else if (r_drn == DRN_LAST) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= w_pass_nxt;
          r_state <= S_FIN;
        end else begin
          r_drn <= r_drn + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
